// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared state encoding, widths and pass shifts for the sequential 32x32 multiplier
package mul_seq_pkg;

    localparam int HALF_W = 16;
    localparam int PROD_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P0   = 3'd1,
        ST_P1   = 3'd2,
        ST_P2   = 3'd3,
        ST_P3   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [5:0] SHIFT_P0 = 6'd0;
    localparam logic [5:0] SHIFT_P1 = 6'd16;
    localparam logic [5:0] SHIFT_P2 = 6'd16;
    localparam logic [5:0] SHIFT_P3 = 6'd32;

    function automatic logic [5:0] pass_shift(input state_t s);
        case (s)
            ST_P1:   return SHIFT_P1;
            ST_P2:   return SHIFT_P2;
            ST_P3:   return SHIFT_P3;
            default: return SHIFT_P0;
        endcase
    endfunction

endpackage

// File: rtl/dadda16bit.sv
// rtl/dadda16bit.sv - 16x16 unsigned combinational multiplier shared by the multiply passes
module dadda16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    assign p = {16'b0, a} * {16'b0, b};

endmodule

// File: rtl/mul32_seq_ctrl.sv
// rtl/mul32_seq_ctrl.sv - multi-cycle 32x32 unsigned multiplier built from four 16x16 passes
module mul32_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_p,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    state_t              state, state_nx;
    logic [31:0]         a_q, b_q;
    logic [TAG_W-1:0]    tag_q;
    logic [PROD_W-1:0]   acc, acc_sum, pp_ext;
    logic [HALF_W-1:0]   mul_a, mul_b;
    logic [2*HALF_W-1:0] pp;
    logic [5:0]          shift;
    logic                accept, zero_op;

    assign accept  = in_valid && in_ready;
    assign zero_op = ZERO_SKIP && ((a_q == 32'd0) || (b_q == 32'd0));

    dadda16bit u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (pp)
    );

    assign pp_ext  = {32'b0, pp} << shift;
    assign acc_sum = acc + pp_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) state_nx = ST_P0;
                ST_P0:   state_nx = zero_op ? ST_DONE : ST_P1;
                ST_P1:   state_nx = ST_P2;
                ST_P2:   state_nx = ST_P3;
                ST_P3:   state_nx = ST_DONE;
                ST_DONE: begin
                    if (accept)         state_nx = ST_P0;
                    else if (out_ready) state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Multiplier operands are parked at zero outside the pass states.
    always_comb begin
        in_ready  = !flush && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
        out_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
        shift     = pass_shift(state);
        mul_a     = '0;
        mul_b     = '0;
        case (state)
            ST_P0: begin mul_a = a_q[15:0];  mul_b = b_q[15:0];  end
            ST_P1: begin mul_a = a_q[15:0];  mul_b = b_q[31:16]; end
            ST_P2: begin mul_a = a_q[31:16]; mul_b = b_q[15:0];  end
            ST_P3: begin mul_a = a_q[31:16]; mul_b = b_q[31:16]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            acc     <= '0;
            out_p   <= '0;
            out_tag <= '0;
        end else if (flush) begin
            acc <= '0;
        end else begin
            if (accept) begin
                a_q   <= in_a;
                b_q   <= in_b;
                tag_q <= in_tag;
                acc   <= '0;
            end else if ((state == ST_P0) || (state == ST_P1) ||
                         (state == ST_P2) || (state == ST_P3)) begin
                acc <= acc_sum;
            end
            // Result registers only move when entering DONE, so they hold under backpressure.
            if (state == ST_P3) begin
                out_p   <= acc_sum;
                out_tag <= tag_q;
            end else if ((state == ST_P0) && zero_op) begin
                out_p   <= '0;
                out_tag <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// tb/tb_mul32_seq_ctrl.sv - self-checking bench for mul32_seq_ctrl
module tb_mul32_seq_ctrl;

    localparam bit ZS = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_p;
    logic [3:0]  out_tag;
    logic        busy;

    logic        z_valid = 1'b0;
    logic        z_ready;
    logic        z_out_valid;
    logic [63:0] z_p;
    logic [3:0]  z_tag;
    logic        z_busy;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mul32_seq_ctrl #(.TAG_W(4), .ZERO_SKIP(ZS)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_tag(out_tag), .busy(busy)
    );

    mul32_seq_ctrl #(.TAG_W(4), .ZERO_SKIP(1'b0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(z_valid), .in_ready(z_ready),
        .in_a(32'h0), .in_b(32'h12345678), .in_tag(4'h2),
        .out_valid(z_out_valid), .out_ready(1'b1),
        .out_p(z_p), .out_tag(z_tag), .busy(z_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: an op in flight with edges remaining, and a held result.
    logic        m_inflight = 1'b0;
    logic        m_valid = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_a = '0, m_b = '0;
    logic [3:0]  m_optag = '0;
    logic [63:0] m_p = '0;
    logic [3:0]  m_tag = '0;
    logic        exp_in_ready;

    assign exp_in_ready = !flush && ((!m_inflight && !m_valid) || (m_valid && out_ready));

    initial begin
        logic acc_ok;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_inflight = 1'b0;
                m_valid    = 1'b0;
                m_cnt      = 0;
            end else begin
                acc_ok = in_valid && exp_in_ready;
                if (flush) begin
                    m_inflight = 1'b0;
                    m_valid    = 1'b0;
                end else begin
                    if (m_valid && out_ready) m_valid = 1'b0;
                    if (m_inflight) begin
                        m_cnt = m_cnt - 1;
                        if (m_cnt == 0) begin
                            m_inflight = 1'b0;
                            m_valid    = 1'b1;
                            m_p        = {32'b0, m_a} * {32'b0, m_b};
                            m_tag      = m_optag;
                        end
                    end
                    if (acc_ok) begin
                        m_inflight = 1'b1;
                        m_a        = in_a;
                        m_b        = in_b;
                        m_optag    = in_tag;
                        m_cnt      = (ZS && (in_a == 32'd0 || in_b == 32'd0)) ? 1 : 4;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("out_valid", {63'b0, out_valid}, {63'b0, m_valid});
                chk("in_ready", {63'b0, in_ready}, {63'b0, exp_in_ready});
                chk("busy", {63'b0, busy}, {63'b0, m_inflight || m_valid});
                if (m_valid) begin
                    chk("out_p", out_p, m_p);
                    chk("out_tag", {60'b0, out_tag}, {60'b0, m_tag});
                end
            end
        end
    end

    // Called #1 after a posedge; returns #1 after the accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        int n;
        n = 0;
        in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
        while (!exp_in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edges counted including the accept edge.
    task automatic measure(output int lat);
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = 99;
    endtask

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_out_p", out_p, 64'd0);
        chk("rst_out_tag", {60'b0, out_tag}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(32'h00010003, 32'h00020005, 4'h3);
        measure(lat);
        chk("lat_basic", 64'(lat), 64'd5);
        chk("p_basic", out_p, 64'h00000002000B000F);
        chk("tag_basic", {60'b0, out_tag}, 64'h3);
        @(posedge clk); #1;

        send(32'hFFFFFFFF, 32'hFFFFFFFF, 4'h1);
        measure(lat);
        chk("p_allones", out_p, 64'hFFFFFFFE00000001);
        @(posedge clk); #1;

        send(32'h0, 32'h12345678, 4'h5);
        measure(lat);
        chk("lat_zskip", 64'(lat), 64'd2);
        chk("p_zskip", out_p, 64'd0);
        @(posedge clk); #1;

        z_valid = 1'b1;
        @(posedge clk); #1;
        z_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 20 && !z_out_valid; i++) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("lat_nozskip", 64'(lat), 64'd5);
        chk("p_nozskip", z_p, 64'd0);
        @(posedge clk); #1;

        out_ready = 1'b0;
        send(32'h00001234, 32'h00005678, 4'h9);
        measure(lat);
        chk("lat_bp", 64'(lat), 64'd5);
        in_a = 32'hFFFFFFFF; in_b = 32'h2; in_tag = 4'hA; in_valid = 1'b1;
        repeat (7) begin
            @(negedge clk);
            chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
            chk("bp_out_p", out_p, 64'h0000000006260060);
            chk("bp_out_tag", {60'b0, out_tag}, 64'h9);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        measure(lat);
        chk("lat_b2b", 64'(lat), 64'd5);
        chk("p_b2b", out_p, 64'h00000001FFFFFFFE);
        chk("tag_b2b", {60'b0, out_tag}, 64'hA);
        @(posedge clk); #1;

        send(32'h00010000, 32'h00010000, 4'h4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {63'b0, busy}, 64'd0);
        repeat (6) begin
            @(negedge clk);
            chk("flush_no_valid", {63'b0, out_valid}, 64'd0);
        end
        @(posedge clk); #1;
        send(32'h00010000, 32'h00010000, 4'h7);
        measure(lat);
        chk("lat_after_flush", 64'(lat), 64'd5);
        chk("p_after_flush", out_p, 64'h0000000100000000);
        @(posedge clk); #1;

        send(32'h00000007, 32'h00000009, 4'h6);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("arst_busy", {63'b0, busy}, 64'd0);
        chk("arst_out_p", out_p, 64'd0);
        chk("arst_out_tag", {60'b0, out_tag}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_in_ready", {63'b0, in_ready}, 64'd1);

        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(1) == 1);
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(19) == 0);
            in_a      = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
            in_b      = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
            in_tag    = 4'($urandom_range(15));
            @(posedge clk); #1;
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nerr);
        $finish;
    end

endmodule
